// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Write-side companion to the CPU instruction memory. Receives a byte stream
//   (first byte = word count N, then 4N bytes, MSB first), assembles 32-bit
//   words and writes them to consecutive word slots starting at address 0.
//   The CPU is held in reset until a complete image has been written.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a new load (ignored while busy)
//   in_valid   stream byte valid
//   in_ready   stream byte ready (high in LEN and DATA only)
//   in_data    stream byte
//   im_we      instruction-memory write strobe, one cycle per word
//   im_waddr   word-aligned byte address (word_index << 2)
//   im_wdata   assembled instruction word
//   busy       high while loading (LEN, DATA, WRITE)
//   done       high once the image is written
//   err        high after an illegal word count
//   cpu_rst_n  active-low CPU reset, released only in DONE
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int DEPTH_LOG2 = 5,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  localparam logic [8:0] DEPTH_MAX = 9'(1 << DEPTH_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic                  in_ready_q, im_we_q, busy_q, done_q, err_q, cpu_rst_n_q;
  logic                  accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end

      S_LEN: begin
        if (accept) begin
          if ((in_data == 8'd0) || ({1'b0, in_data} > DEPTH_MAX)) begin
            state_d = S_ERR;
          end else begin
            count_d = in_data[DEPTH_LOG2:0];
            widx_d  = '0;
            bcnt_d  = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d = {shift_q[23:0], in_data};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Latch the write beat now so im_we/addr/data are registered
            // outputs during the single WRITE cycle.
            wdata_d = {shift_q[23:0], in_data};
            waddr_d = {{(ADDR_W-DEPTH_LOG2-2){1'b0}}, widx_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if ({1'b0, widx_q} == (count_q - (DEPTH_LOG2+1)'(1))) begin
          state_d = S_DONE;
        end else begin
          widx_d  = widx_q + 1'b1;
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state itself (e.g. cpu_rst_n falls as DONE -> LEN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      widx_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      in_ready_q  <= (state_d == S_LEN) || (state_d == S_DATA);
      im_we_q     <= (state_d == S_WRITE);
      busy_q      <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
      cpu_rst_n_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign im_we     = im_we_q;
  assign im_waddr  = waddr_q;
  assign im_wdata  = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_im_loader.sv
`timescale 1ns/1ps
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        busy, done, err, cpu_rst_n;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] stim_words[$];
  wr_t         mon_e;

  im_loader #(.DEPTH_LOG2(5), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", im_waddr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("waddr", im_waddr, mon_e.a);
        chk("wdata", im_wdata, mon_e.d);
        chk("in_ready_during_write", {31'b0, in_ready}, 32'd0);
        chk("done_during_write", {31'b0, done}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_im_we"}, {31'b0, im_we}, 32'd0);
    chk({tag, "_im_waddr"}, im_waddr, 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, 32'd0);
  endtask

  // All tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int g, t;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: in_ready got 0 required 1 within 100 cycles");
      in_valid = 1'b0;
      start    = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("after_start_busy", {31'b0, busy}, 32'd1);
    chk("after_start_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    chk("after_start_err", {31'b0, err}, 32'd0);
    chk("after_start_done", {31'b0, done}, 32'd0);
  endtask

  task automatic send_word(input int w, input int gmin, input int gmax, input int start_at);
    logic [31:0] word;
    wr_t e;
    word = (stim_words.size() > 0) ? stim_words.pop_front() : $urandom;
    e.a = w * 4;
    e.d = word;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (w * 4 + k == start_at) start = 1'b1;
      send_byte(8'((word >> (24 - 8 * k)) & 32'hFF), gmin, gmax);
    end
  endtask

  // Reference behaviour: legal counts 1..32 give N sequential writes then DONE;
  // anything else gives ERR with no writes.
  task automatic run_load(input int n, input int gmin, input int gmax, input int start_at);
    bit legal;
    int t;
    legal = (n >= 1) && (n <= 32);
    pulse_start();
    send_byte(8'(n), gmin, gmax);
    if (legal) begin
      for (int w = 0; w < n; w++) send_word(w, gmin, gmax, start_at);
    end
    t = 0;
    while (!(done || err) && t < 200) begin @(posedge clk); #1; t++; end
    chk("end_done", {31'b0, done}, {31'b0, legal});
    chk("end_err", {31'b0, err}, {31'b0, !legal});
    chk("end_cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, legal});
    chk("end_in_ready", {31'b0, in_ready}, 32'd0);
    chk("end_busy", {31'b0, busy}, 32'd0);
    chk("end_pending_writes", exp_q.size(), 32'd0);
    exp_q.delete();
    stim_words.delete();
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Directed two-word image, valid held high
    stim_words.push_back(32'h00220020);
    stim_words.push_back(32'h00620022);
    run_load(2, 0, 0, -1);

    // Illegal counts
    run_load(0, 0, 0, -1);
    run_load(33, 0, 0, -1);

    // Full image
    run_load(32, 0, 0, -1);

    // Single word with in_valid toggling every other cycle
    run_load(1, 1, 1, -1);

    // Asynchronous reset after 6 accepted bytes (one word already written)
    pulse_start();
    send_byte(8'd2, 0, 0);
    send_word(0, 0, 0, -1);
    send_byte(8'hA5, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    chk("midload_pending_writes", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(1, 0, 0, -1);

    // start during DATA ignored, then reload from DONE
    run_load(3, 0, 1, 5);
    run_load(4, 0, 0, -1);

    // Randomized loads
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(4, 0) == 0)
        n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, 33);
      else
        n = $urandom_range(32, 1);
      run_load(n, 0, $urandom_range(2, 0), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
